// File: rtl/commit_unit_v2.sv
// commit_unit_v2: in-order multi-slot commit stage with precise traps, branch redirect and post-flush drain.
// Retires the contiguous oldest completed ROB slots; all side-effect outputs are registered one cycle later.
module commit_unit_v2 #(
  parameter int COMMIT_W = 4,
  parameter int XLEN = 32,
  parameter int ARCH_REGS = 32,
  parameter int PHYS_W = 6,
  parameter int ROB_IDX_W = 5,
  parameter int MAX_ST = 1,
  localparam int CW = $clog2(COMMIT_W + 1)
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [COMMIT_W-1:0]                 rob_valid,
  input  logic [COMMIT_W-1:0][4:0]            rob_arch_rd,
  input  logic [COMMIT_W-1:0][PHYS_W-1:0]     rob_phys_rd,
  input  logic [COMMIT_W-1:0]                 rob_exception,
  input  logic [COMMIT_W-1:0][4:0]            rob_exc_cause,
  input  logic [COMMIT_W-1:0][XLEN-1:0]       rob_exc_tval,
  input  logic [COMMIT_W-1:0]                 rob_is_store,
  input  logic [COMMIT_W-1:0]                 rob_is_branch,
  input  logic [COMMIT_W-1:0]                 rob_mispredict,
  input  logic [COMMIT_W-1:0]                 rob_br_taken,
  input  logic [COMMIT_W-1:0][XLEN-1:0]       rob_pc,
  input  logic [COMMIT_W-1:0][XLEN-1:0]       rob_br_target,
  input  logic [COMMIT_W-1:0][ROB_IDX_W-1:0]  rob_idx,
  input  logic                                rob_empty,
  input  logic [XLEN-1:0]                     mtvec,
  input  logic                                lsu_store_ready,
  output logic [CW-1:0]                       rob_retire_cnt,
  output logic [COMMIT_W-1:0][PHYS_W-1:0]     prf_rtag,
  input  logic [COMMIT_W-1:0][XLEN-1:0]       prf_rdata,
  output logic [COMMIT_W-1:0]                 arf_wen,
  output logic [COMMIT_W-1:0][4:0]            arf_waddr,
  output logic [COMMIT_W-1:0][XLEN-1:0]       arf_wdata,
  output logic [COMMIT_W-1:0]                 free_en,
  output logic [COMMIT_W-1:0][PHYS_W-1:0]     free_phys,
  output logic [COMMIT_W-1:0]                 rename_commit_en,
  output logic [COMMIT_W-1:0][4:0]            rename_commit_arch,
  output logic [COMMIT_W-1:0][PHYS_W-1:0]     rename_commit_phys,
  output logic [COMMIT_W-1:0]                 lsu_commit_en,
  output logic [COMMIT_W-1:0][ROB_IDX_W-1:0]  lsu_commit_rob_idx,
  output logic                                exception_valid,
  output logic [4:0]                          exception_cause,
  output logic [XLEN-1:0]                     exception_pc,
  output logic [XLEN-1:0]                     exception_tval,
  output logic                                flush_pipeline,
  output logic [XLEN-1:0]                     flush_pc,
  output logic                                bp_update_en,
  output logic [XLEN-1:0]                     bp_update_pc,
  output logic                                bp_update_taken,
  output logic [XLEN-1:0]                     bp_update_target,
  output logic [63:0]                         perf_insns,
  output logic [63:0]                         perf_exceptions,
  output logic [63:0]                         perf_mispredicts,
  output logic [63:0]                         perf_stall_cycles
);
  typedef enum logic {RUN, DRAIN} state_t;
  state_t state_q, state_d;
  logic run, stop, exc, mis, bp;
  logic [CW-1:0] cnt, st_cnt;
  logic [ARCH_REGS-1:0][PHYS_W-1:0] rat_q, rat_d;
  logic [COMMIT_W-1:0] arf_wen_q, arf_wen_d, free_en_q, free_en_d, ren_en_q, ren_en_d, lsu_en_q, lsu_en_d;
  logic [COMMIT_W-1:0][4:0] arf_waddr_q, arf_waddr_d, ren_arch_q, ren_arch_d;
  logic [COMMIT_W-1:0][XLEN-1:0] arf_wdata_q, arf_wdata_d;
  logic [COMMIT_W-1:0][PHYS_W-1:0] free_phys_q, free_phys_d, ren_phys_q, ren_phys_d;
  logic [COMMIT_W-1:0][ROB_IDX_W-1:0] lsu_idx_q, lsu_idx_d;
  logic exc_valid_q, exc_valid_d, flush_q, flush_d, bp_en_q, bp_en_d, bp_taken_q, bp_taken_d;
  logic [4:0] exc_cause_q, exc_cause_d;
  logic [XLEN-1:0] exc_pc_q, exc_pc_d, exc_tval_q, exc_tval_d, flush_pc_q, flush_pc_d;
  logic [XLEN-1:0] bp_pc_q, bp_pc_d, bp_target_q, bp_target_d;
  logic [63:0] p_insns_q, p_insns_d, p_exc_q, p_exc_d, p_mis_q, p_mis_d, p_stall_q, p_stall_d;

  // The drain-exit cycle (rob_empty seen in DRAIN) already behaves as RUN.
  always_comb begin
    run = state_q == RUN || rob_empty;
    stop = 1'b0;
    exc = 1'b0;
    mis = 1'b0;
    bp = 1'b0;
    cnt = '0;
    st_cnt = '0;
    rat_d = rat_q;
    arf_wen_d = '0;
    arf_waddr_d = arf_waddr_q;
    arf_wdata_d = arf_wdata_q;
    free_en_d = '0;
    free_phys_d = free_phys_q;
    ren_en_d = '0;
    ren_arch_d = ren_arch_q;
    ren_phys_d = ren_phys_q;
    lsu_en_d = '0;
    lsu_idx_d = lsu_idx_q;
    exc_valid_d = 1'b0;
    exc_cause_d = exc_cause_q;
    exc_pc_d = exc_pc_q;
    exc_tval_d = exc_tval_q;
    flush_d = 1'b0;
    flush_pc_d = flush_pc_q;
    bp_en_d = 1'b0;
    bp_pc_d = bp_pc_q;
    bp_taken_d = bp_taken_q;
    bp_target_d = bp_target_q;
    for (int i = 0; i < COMMIT_W; i++) begin
      if (run && !stop) begin
        if (!rob_valid[i]) stop = 1'b1;
        else if (rob_exception[i]) begin
          stop = 1'b1;
          exc = 1'b1;
          exc_valid_d = 1'b1;
          exc_cause_d = rob_exc_cause[i];
          exc_pc_d = rob_pc[i];
          exc_tval_d = rob_exc_tval[i];
          flush_d = 1'b1;
          flush_pc_d = mtvec;
        end else if (rob_is_store[i] && (!lsu_store_ready || st_cnt == CW'(MAX_ST))) stop = 1'b1;
        else begin
          cnt = cnt + CW'(1);
          ren_en_d[i] = 1'b1;
          ren_arch_d[i] = rob_arch_rd[i];
          ren_phys_d[i] = rob_phys_rd[i];
          // Walking a private RAT copy makes a later same-rd slot free the earlier slot's tag.
          if (rob_arch_rd[i] != 5'd0) begin
            arf_wen_d[i] = 1'b1;
            arf_waddr_d[i] = rob_arch_rd[i];
            arf_wdata_d[i] = prf_rdata[i];
            free_en_d[i] = 1'b1;
            free_phys_d[i] = rat_d[rob_arch_rd[i]];
            rat_d[rob_arch_rd[i]] = rob_phys_rd[i];
          end
          if (rob_is_store[i]) begin
            st_cnt = st_cnt + CW'(1);
            lsu_en_d[i] = 1'b1;
            lsu_idx_d[i] = rob_idx[i];
          end
          if (rob_is_branch[i] && !bp) begin
            bp = 1'b1;
            bp_en_d = 1'b1;
            bp_pc_d = rob_pc[i];
            bp_taken_d = rob_br_taken[i];
            bp_target_d = rob_br_target[i];
          end
          if (rob_mispredict[i]) begin
            stop = 1'b1;
            mis = 1'b1;
            flush_d = 1'b1;
            flush_pc_d = rob_br_taken[i] ? rob_br_target[i] : rob_pc[i] + XLEN'(4);
          end
        end
      end
    end
    state_d = flush_d ? DRAIN : run ? RUN : DRAIN;
    p_insns_d = p_insns_q + 64'(cnt);
    p_exc_d = p_exc_q + 64'(exc);
    p_mis_d = p_mis_q + 64'(mis);
    p_stall_d = p_stall_q + 64'(run && rob_valid[0] && cnt == '0 && !flush_d);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RUN;
      for (int i = 0; i < ARCH_REGS; i++) rat_q[i] <= PHYS_W'(i);
      {arf_wen_q, arf_waddr_q, arf_wdata_q, free_en_q, free_phys_q} <= '0;
      {ren_en_q, ren_arch_q, ren_phys_q, lsu_en_q, lsu_idx_q} <= '0;
      {exc_valid_q, exc_cause_q, exc_pc_q, exc_tval_q, flush_q, flush_pc_q} <= '0;
      {bp_en_q, bp_pc_q, bp_taken_q, bp_target_q} <= '0;
      {p_insns_q, p_exc_q, p_mis_q, p_stall_q} <= '0;
    end else begin
      state_q <= state_d;
      rat_q <= rat_d;
      {arf_wen_q, arf_waddr_q, arf_wdata_q, free_en_q, free_phys_q} <= {arf_wen_d, arf_waddr_d, arf_wdata_d, free_en_d, free_phys_d};
      {ren_en_q, ren_arch_q, ren_phys_q, lsu_en_q, lsu_idx_q} <= {ren_en_d, ren_arch_d, ren_phys_d, lsu_en_d, lsu_idx_d};
      {exc_valid_q, exc_cause_q, exc_pc_q, exc_tval_q, flush_q, flush_pc_q} <= {exc_valid_d, exc_cause_d, exc_pc_d, exc_tval_d, flush_d, flush_pc_d};
      {bp_en_q, bp_pc_q, bp_taken_q, bp_target_q} <= {bp_en_d, bp_pc_d, bp_taken_d, bp_target_d};
      {p_insns_q, p_exc_q, p_mis_q, p_stall_q} <= {p_insns_d, p_exc_d, p_mis_d, p_stall_d};
    end
  end

  assign rob_retire_cnt = cnt;
  assign prf_rtag = rob_phys_rd;
  assign {arf_wen, arf_waddr, arf_wdata, free_en, free_phys} = {arf_wen_q, arf_waddr_q, arf_wdata_q, free_en_q, free_phys_q};
  assign {rename_commit_en, rename_commit_arch, rename_commit_phys} = {ren_en_q, ren_arch_q, ren_phys_q};
  assign {lsu_commit_en, lsu_commit_rob_idx} = {lsu_en_q, lsu_idx_q};
  assign {exception_valid, exception_cause, exception_pc, exception_tval} = {exc_valid_q, exc_cause_q, exc_pc_q, exc_tval_q};
  assign {flush_pipeline, flush_pc} = {flush_q, flush_pc_q};
  assign {bp_update_en, bp_update_pc, bp_update_taken, bp_update_target} = {bp_en_q, bp_pc_q, bp_taken_q, bp_target_q};
  assign {perf_insns, perf_exceptions, perf_mispredicts, perf_stall_cycles} = {p_insns_q, p_exc_q, p_mis_q, p_stall_q};
endmodule

// File: doc/commit_unit_v2.md
Name: commit_unit_v2

Overview:
- Parametrised next-generation in-order commit stage between the ROB, PRF, ARF, free list, rename, LSU and branch predictor.
- Retires up to COMMIT_W contiguous oldest ROB entries per cycle and returns an explicit retire count to the ROB.
- Commits instructions older than a faulting or mispredicted slot (precise exceptions), redirects fetch through mtvec or the resolved branch path, and holds off commit in a DRAIN state until the ROB empties after a flush.

Parameters:
- COMMIT_W, 4, commit slots per cycle (1..8)
- XLEN, 32, data/PC width
- ARCH_REGS, 32, architectural registers
- PHYS_W, 6, physical tag width
- ROB_IDX_W, 5, ROB index width
- MAX_ST, 1, stores committable per cycle (1..COMMIT_W)

Ports:
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- rob_valid  in  COMMIT_W  slot i holds a completed instruction; slot 0 is oldest
- rob_arch_rd  in  COMMIT_W x 5  destination arch register
- rob_phys_rd  in  COMMIT_W x PHYS_W  destination phys tag
- rob_exception  in  COMMIT_W  slot faulted
- rob_exc_cause  in  COMMIT_W x 5  fault cause
- rob_exc_tval  in  COMMIT_W x XLEN  fault value
- rob_is_store, rob_is_branch, rob_mispredict, rob_br_taken  in  COMMIT_W each  metadata
- rob_pc, rob_br_target  in  COMMIT_W x XLEN  PC / resolved target
- rob_idx  in  COMMIT_W x ROB_IDX_W  ROB index
- rob_empty  in  1  ROB holds no entries
- mtvec  in  XLEN  trap vector
- lsu_store_ready  in  1  store buffer accepts commits this cycle
- rob_retire_cnt  out  $clog2(COMMIT_W+1)  combinational entries the ROB dequeues this edge
- prf_rtag  out  COMMIT_W x PHYS_W  combinational, equals rob_phys_rd
- prf_rdata  in  COMMIT_W x XLEN  PRF read data
- arf_wen / arf_waddr / arf_wdata  out  COMMIT_W / x5 / xXLEN  ARF write
- free_en / free_phys  out  COMMIT_W / xPHYS_W  free-list release
- rename_commit_en / _arch / _phys  out  COMMIT_W / x5 / xPHYS_W  committed RAT update
- lsu_commit_en / lsu_commit_rob_idx  out  COMMIT_W / xROB_IDX_W  store commit
- exception_valid, exception_cause(5), exception_pc, exception_tval  out  trap report
- flush_pipeline  out  1  one-cycle flush pulse
- flush_pc  out  XLEN  redirect PC
- bp_update_en, bp_update_pc, bp_update_taken, bp_update_target  out  predictor training
- perf_insns, perf_exceptions, perf_mispredicts, perf_stall_cycles  out  64 each  counters

Behaviour:
- Reset: every registered output is 0, committed RAT is identity (arch i maps to phys i), state is RUN, all counters are 0.
- Slot scan (combinational, RUN only), i from 0 upward; the scan stops at the first condition that holds:
  - (a) !rob_valid[i]: slot not committed.
  - (b) rob_exception[i]: slot not committed; it is the trap slot.
  - (c) rob_is_store[i] and (!lsu_store_ready or MAX_ST stores already counted): slot not committed.
  - (d) rob_mispredict[i]: slot IS committed, then the scan stops.
- rob_retire_cnt = number of committed slots; rob_retire_cnt = 0 in DRAIN.
- Committed-slot outputs are all registered, one-cycle latency after the edge where rob_retire_cnt counted the slot:
  - arch_rd != 0: arf write of prf_rdata; free_en with the prior mapping; RAT updated.
  - arch_rd == 0: no ARF write, no free, no RAT change; rename_commit_en still pulses.
- Same-cycle same-rd: the later slot frees the earlier slot's phys_rd (not the RAT entry); the final RAT holds the youngest slot's mapping.
- Stores: lsu_commit_en[i] and rob_idx registered for each committed store.
- BP: bp_update_en for the oldest committed branch only; fields come from that slot.
- Exception stop at slot k:
  - exception_valid = 1; cause, tval and pc come from slot k.
  - flush_pipeline = 1, flush_pc = mtvec.
  - perf_exceptions +1; state goes to DRAIN.
- Mispredict at slot k:
  - flush_pipeline = 1; flush_pc = br_target if taken, else pc+4.
  - perf_mispredicts +1; state goes to DRAIN.
- Exception and mispredict cannot both apply: the scan stops at whichever slot is oldest.
- DRAIN: no commits. Return to RUN on the first cycle rob_empty = 1; that cycle may already commit.
- perf_insns += rob_retire_cnt every cycle.
- perf_stall_cycles +1 when in RUN, rob_valid[0] = 1, retire_cnt = 0, and no flush is raised.
- Pulses (wen, free_en, flush_pipeline, exception_valid, bp_update_en, lsu_commit_en) are single-cycle. Data outputs hold their last value when not pulsed.
- Reset asserted mid-operation returns all state to reset values asynchronously.

Test Plan:
- Four valid ALU slots, rd = 5,6,7,8, phys 40..43 -> rob_retire_cnt = 4; next cycle arf_wen = 4'b1111, free_phys = 5,6,7,8, perf_insns = 4.
- Slots rd = 3 (phys 33) and rd = 3 (phys 34) -> free_phys[0] = 3, free_phys[1] = 33; RAT[3] = 34.
- Slot 2 exception, cause 2, pc 0x108, mtvec 0x100 -> retire_cnt = 2, then exception_pc = 0x108, flush_pc = 0x100. In DRAIN retire_cnt = 0 until rob_empty.
- Slot 1 mispredicted not-taken branch at pc 0x200, slot 2 valid -> retire_cnt = 2, flush_pc = 0x204, bp_update_pc = 0x200, bp_update_taken = 0.
- MAX_ST = 1, slots 0 and 1 both stores, lsu_store_ready = 1 -> retire_cnt = 1. With lsu_store_ready = 0 -> retire_cnt = 0 and perf_stall_cycles +1.
- rd = 0 slot -> no arf_wen, no free_en, rename_commit_en = 1. Assert reset mid-DRAIN -> state RUN, RAT identity, all outputs 0.
